// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral exposing NUM_REGS registers with per-register write strobes.
// Define SPI_REGFILE_READ_EN to build the CIPO read-back path; otherwise CIPO/cipo_oe are tied low.
module spi_regfile #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         nCS,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe
);
    localparam int F  = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(F + 1);
    localparam int W  = (1 + ADDR_W > DATA_W) ? 1 + ADDR_W : DATA_W;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t              r_state;
    logic [2:0]          r_sclk;
    logic [1:0]          r_ncs;
    logic [1:0]          r_copi;
    logic [CW-1:0]       r_cnt;
    logic [W-2:0]        r_shift;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_rise;
    logic [W-1:0]        w_shift_nx;
    assign w_rise     = r_sclk[1] & ~r_sclk[2];
    assign w_shift_nx = {r_shift, r_copi[1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk <= '0;
            r_ncs  <= '1;
            r_copi <= '0;
        end else begin
            r_sclk <= {r_sclk[1:0], SCLK};
            r_ncs  <= {r_ncs[0], nCS};
            r_copi <= {r_copi[0], COPI};
        end
    end
    // nCS high is checked first so it overrides any SCLK edge seen in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            regs_flat <= '0;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            if (r_ncs[1]) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= CMD;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                    CMD: if (w_rise) begin
                        r_shift <= w_shift_nx[W-2:0];
                        r_cnt   <= r_cnt + CW'(1);
                        if (r_cnt == CW'(ADDR_W)) begin
                            r_rw    <= w_shift_nx[ADDR_W];
                            r_addr  <= w_shift_nx[ADDR_W-1:0];
                            r_state <= DATA;
                        end
                    end
                    DATA: if (w_rise) begin
                        r_shift <= w_shift_nx[W-2:0];
                        r_cnt   <= r_cnt + CW'(1);
                        if (r_cnt == CW'(F - 1)) begin
                            r_state <= DONE;
                            for (int i = 0; i < NUM_REGS; i++)
                                if (r_rw && r_addr == ADDR_W'(i)) begin
                                    regs_flat[i*DATA_W +: DATA_W] <= w_shift_nx[DATA_W-1:0];
                                    wr_strobe[i]                  <= 1'b1;
                                end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef SPI_REGFILE_READ_EN
    logic                w_fall;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   r_out;
    logic                r_cipo;
    assign w_fall = ~r_sclk[1] & r_sclk[2];
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_shift_nx[ADDR_W-1:0] == ADDR_W'(i)) w_rd_val = regs_flat[i*DATA_W +: DATA_W];
    end
    // MSB is presented on the first fall after the address so the controller samples it on the next rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_cipo <= 1'b0;
        end else if (r_ncs[1] || r_state == IDLE) begin
            r_cipo <= 1'b0;
        end else if (r_state == CMD) begin
            r_cipo <= 1'b0;
            if (w_rise && r_cnt == CW'(ADDR_W)) r_out <= w_shift_nx[ADDR_W] ? '0 : w_rd_val;
        end else if (r_state == DATA && w_fall) begin
            r_cipo <= r_out[DATA_W-1];
            r_out  <= r_out << 1;
        end
    end
    assign CIPO    = r_cipo;
    assign cipo_oe = ~r_ncs[1];
`else
    assign CIPO    = 1'b0;
    assign cipo_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed SPI frames against spi_regfile with default parameters.
module tb_spi_regfile;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        nCS = 1'b1;
    logic        COPI = 1'b0;
    logic        CIPO;
    logic        cipo_oe;
    logic [39:0] regs_flat;
    logic [4:0]  wr_strobe;
    int          ncmp = 0;
    int          nfail = 0;
    int          scnt [5] = '{0, 0, 0, 0, 0};
    int          base [5];
    logic [7:0]  rd;
    logic        oe;
    logic        exp_oe;

    spi_regfile dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(nCS), .COPI(COPI),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_flat(regs_flat), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 5; i++)
            if (wr_strobe[i]) scnt[i]++;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) base[i] = scnt[i];
    endtask

    task automatic chk_strobe(input string tag, input logic [4:0] exp_mask, input int exp_total);
        logic [4:0] mask;
        int         total;
        mask  = '0;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            mask[i] = (scnt[i] != base[i]);
            total  += scnt[i] - base[i];
        end
        chk({tag, "_mask"}, 40'(mask), 40'(exp_mask));
        chk({tag, "_cycles"}, 40'(total), 40'(exp_total));
    endtask

    task automatic frame(input logic rw, input logic [6:0] a, input logic [7:0] d, input int nbits,
                         input bit keep, output logic [7:0] r, output logic o);
        logic [15:0] f;
        f    = {rw, a, d};
        r    = '0;
        nCS  = 1'b0;
        #60;
        o    = cipo_oe;
        for (int k = 0; k < nbits; k++) begin
            COPI = (k < 16) ? f[15-k] : 1'b0;
            #50 SCLK = 1'b1;
            if (k >= 8 && k < 16) r = {r[6:0], CIPO};
            #50 SCLK = 1'b0;
        end
        COPI = 1'b0;
        if (!keep) begin
            #50 nCS = 1'b1;
            #100;
        end
    endtask

    initial begin
`ifdef SPI_REGFILE_READ_EN
        exp_oe = 1'b1;
`else
        exp_oe = 1'b0;
`endif
        #22;
        chk("rst_regs", regs_flat, 40'h0);
        chk("rst_strobe", 40'(wr_strobe), 40'h0);
        chk("rst_cipo", 40'(CIPO), 40'h0);
        chk("rst_oe", 40'(cipo_oe), 40'h0);
        rst_n = 1'b1;
        #50;
        chk("idle_regs", regs_flat, 40'h0);

        snap();
        frame(1'b1, 7'h02, 8'hA5, 16, 1'b0, rd, oe);
        chk("wr2_regs", regs_flat, 40'h00_00_A5_00_00);
        chk_strobe("wr2_strobe", 5'b00100, 1);
        chk("wr2_oe", 40'(oe), 40'(exp_oe));
        chk("idle_oe", 40'(cipo_oe), 40'h0);

        snap();
        frame(1'b1, 7'h05, 8'hFF, 16, 1'b0, rd, oe);
        chk("wr5_oor_regs", regs_flat, 40'h00_00_A5_00_00);
        chk_strobe("wr5_oor_strobe", 5'b00000, 0);

        snap();
        frame(1'b1, 7'h01, 8'h3C, 16, 1'b0, rd, oe);
        chk("wr1_regs", regs_flat, 40'h00_00_A5_3C_00);
        chk_strobe("wr1_strobe", 5'b00010, 1);

        snap();
        frame(1'b0, 7'h01, 8'hFF, 16, 1'b0, rd, oe);
`ifdef SPI_REGFILE_READ_EN
        chk("rd1_data", 40'(rd), 40'h3C);
`else
        chk("rd1_data", 40'(rd), 40'h00);
`endif
        chk("rd1_regs", regs_flat, 40'h00_00_A5_3C_00);
        chk_strobe("rd1_strobe", 5'b00000, 0);
        frame(1'b0, 7'h7F, 8'h00, 16, 1'b0, rd, oe);
        chk("rd7f_data", 40'(rd), 40'h00);
        chk("idle_cipo", 40'(CIPO), 40'h0);

        snap();
        frame(1'b1, 7'h00, 8'h11, 10, 1'b0, rd, oe);
        chk("abort_regs", regs_flat, 40'h00_00_A5_3C_00);
        frame(1'b1, 7'h00, 8'h22, 16, 1'b0, rd, oe);
        chk("after_abort_regs", regs_flat, 40'h00_00_A5_3C_22);
        chk_strobe("after_abort_strobe", 5'b00001, 1);

        snap();
        frame(1'b1, 7'h04, 8'h80, 20, 1'b0, rd, oe);
        chk("long_regs", regs_flat, 40'h80_00_A5_3C_22);
        chk_strobe("long_strobe", 5'b10000, 1);

        frame(1'b1, 7'h03, 8'h5A, 12, 1'b1, rd, oe);
        #20 rst_n = 1'b0;
        #20;
        chk("midrst_regs", regs_flat, 40'h0);
        chk("midrst_strobe", 40'(wr_strobe), 40'h0);
        chk("midrst_cipo", 40'(CIPO), 40'h0);
        chk("midrst_oe", 40'(cipo_oe), 40'h0);
        nCS = 1'b1;
        #40 rst_n = 1'b1;
        #50;
        snap();
        frame(1'b1, 7'h03, 8'h5A, 16, 1'b0, rd, oe);
        chk("post_rst_regs", regs_flat, 40'h00_5A_00_00_00);
        chk_strobe("post_rst_strobe", 5'b01000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
